// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, its binary index,
// and an optional hold timeout that preempts long-running owners.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = TIMEOUT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state, state_d;
  logic [2:0]       ptr, ptr_d;
  logic [CNT_W-1:0] hold_cnt, cnt_d;
  logic [7:0]       gnt_d;
  logic [2:0]       idx_d;
  logic             valid_d, pre_d;
  logic             found;
  logic [2:0]       pick, cand;

  // First requester at or after ptr, wrapping mod 8
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // gnt_idx doubles as the owner register while in GRANT
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = hold_cnt;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    pre_d   = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_d = GRANT;
          gnt_d   = 8'(1) << pick;
          idx_d   = pick;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx] || (TIMEOUT_EN && hold_cnt == HOLD_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gnt_idx + 3'd1;
          pre_d   = req[gnt_idx];
        end else begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      hold_cnt  <= cnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      preempt   <= pre_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: a cycle-level model of the arbitration rules is checked
// every cycle, alongside hand-computed literal expectations for the directed scenarios.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       en = 1'b1;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int nvec = 0;
  int nmis = 0;

  rr_arbiter8 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .en       (en),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  // Model: who owns the resource, for how many cycles, and where the search starts
  bit m_busy;
  int m_owner, m_ptr, m_held;
  bit m_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_pre = 0;
    end else begin
      m_pre = 0;
      if (m_busy) begin
        if (!req[m_owner]) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % 8;
        end else if (MAXH != 0 && m_held == MAXH) begin
          m_busy = 0;
          m_pre  = 1;
          m_ptr  = (m_owner + 1) % 8;
        end else begin
          m_held++;
        end
      end else if (en && req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_busy && req[(m_ptr + k) % 8]) begin
            m_busy  = 1;
            m_owner = (m_ptr + k) % 8;
            m_held  = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_gnt", gnt, m_busy ? (1 << m_owner) : 0);
      chk("model_idx", gnt_idx, m_busy ? m_owner : 0);
      chk("model_valid", gnt_valid, m_busy ? 1 : 0);
      chk("model_preempt", preempt, m_pre ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b1;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: asynchronous reset during a grant
    tick(2);
    rst_n = 1'b1;
    req = 8'h08;
    tick(1); chk("t1_gnt", gnt, 8'h08);
    tick(1); chk("t1_hold", gnt, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_gnt", gnt, 0);
    chk("t1_rst_idx", gnt_idx, 0);
    chk("t1_rst_valid", gnt_valid, 0);
    chk("t1_rst_pre", preempt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1); chk("t1_regrant", gnt, 8'h08); chk("t1_regrant_idx", gnt_idx, 3);
    req = 8'h00;
    tick(2);

    // 2: two requesters, low index first then 7
    do_reset();
    req = 8'h81;
    tick(1); chk("t2_g0", gnt, 8'h01); chk("t2_i0", gnt_idx, 0);
    req = 8'h80;
    tick(1); chk("t2_gap", gnt, 8'h00);
    tick(1); chk("t2_g7", gnt, 8'h80); chk("t2_i7", gnt_idx, 7);
    req = 8'h00;
    tick(1); chk("t2_rel", gnt, 8'h00);
    req = 8'h81;
    tick(1); chk("t2_ptr0", gnt, 8'h01);
    req = 8'h00;
    tick(2);

    // 3: fairness, each owner drops its bit after two granted cycles
    do_reset();
    req = 8'hFF;
    tick(1);
    for (int k = 0; k < 9; k++) begin
      chk("t3_grant", gnt, 1 << (k % 8));
      tick(1);
      chk("t3_held", gnt, 1 << (k % 8));
      req[k % 8] = 1'b0;
      tick(1);
      chk("t3_gap", gnt, 0);
      req[k % 8] = 1'b1;
      tick(1);
    end
    req = 8'h00;
    tick(2);

    // 4: timeout after MAXH cycles, then regrant
    do_reset();
    req = 8'h08;
    for (int k = 0; k < MAXH; k++) begin
      tick(1); chk("t4_hold", gnt, 8'h08); chk("t4_nopre", preempt, 0);
    end
    tick(1); chk("t4_to_gnt", gnt, 8'h00); chk("t4_pre", preempt, 1);
    tick(1); chk("t4_regrant", gnt, 8'h08); chk("t4_pre_off", preempt, 0);
    req = 8'h00;
    tick(2);

    // 5: enable gating
    do_reset();
    en = 1'b0;
    req = 8'h10;
    for (int k = 0; k < 10; k++) begin
      tick(1); chk("t5_blocked", gnt, 0);
    end
    en = 1'b1;
    tick(1); chk("t5_gnt", gnt, 8'h10); chk("t5_idx", gnt_idx, 4);
    en = 1'b0;
    tick(1); chk("t5_held", gnt, 8'h10);
    tick(1); chk("t5_held2", gnt, 8'h10);
    req = 8'h00;
    tick(1); chk("t5_rel", gnt, 0);
    en = 1'b1;
    tick(1);

    // 6: pointer wrap past 7
    do_reset();
    req = 8'h20;
    tick(1); chk("t6_g5", gnt, 8'h20);
    req = 8'h00;
    tick(1); chk("t6_rel", gnt, 0);
    req = 8'h21;
    tick(1); chk("t6_g0", gnt, 8'h01); chk("t6_i0", gnt_idx, 0);
    req = 8'h20;
    tick(1); chk("t6_gap", gnt, 0);
    tick(1); chk("t6_g5b", gnt, 8'h20); chk("t6_i5", gnt_idx, 5);
    req = 8'h00;
    tick(2);

    // Pseudo-random traffic, model-checked every cycle
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    req = 8'h00;
    tick(2);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
